muldiv_sequencer: RTL

//  Multi-cycle controller for RV32M ops: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake/data bundle between the EX stage and the M-extension sequencer.
// The master is the pipeline side and the slave is the sequencer.
interface muldiv_sequencer_if #(
    parameter int XLEN = 32
);
    logic            i_start;
    logic            i_kill;
    logic [2:0]      i_op;
    logic [XLEN-1:0] i_data1;
    logic [XLEN-1:0] i_data2;
    logic            o_ready;
    logic            o_busy;
    logic            o_done;
    logic [XLEN-1:0] o_result;

    modport master (
        output i_start, i_kill, i_op, i_data1, i_data2,
        input  o_ready, o_busy, o_done, o_result
    );

    modport slave (
        input  i_start, i_kill, i_op, i_data1, i_data2,
        output o_ready, o_busy, o_done, o_result
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M sequencer: one-cycle registered multiply and a radix-2
// restoring divider (XLEN iterations), followed by a sign-fix cycle.
// Optional macro DIV_EARLY_OUT_EN: divides by zero, or with |divisor| > |dividend|,
// skip the iterations and finish in 3 edges with identical results.
module muldiv_sequencer #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              i_clk,
    input  logic              i_resetn,
    muldiv_sequencer_if.slave bus
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;       // multiplicand, or dividend shifting into quotient
    logic [XLEN-1:0] r_b;       // multiplier, or divisor magnitude
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic            r_neg_q, r_neg_r, r_eo;

    logic            w_accept, w_div_signed, w_neg1, w_neg2, w_early;
    logic [XLEN-1:0] w_mag1, w_mag2;

    assign w_accept     = (r_state == S_IDLE) && bus.i_start && !bus.i_kill;
    // DIV/REM (funct3 100/110) are signed, DIVU/REMU (101/111) are not
    assign w_div_signed = !bus.i_op[0];
    assign w_neg1       = w_div_signed && bus.i_data1[XLEN-1];
    assign w_neg2       = w_div_signed && bus.i_data2[XLEN-1];
    assign w_mag1       = w_neg1 ? -bus.i_data1 : bus.i_data1;
    assign w_mag2       = w_neg2 ? -bus.i_data2 : bus.i_data2;

`ifdef DIV_EARLY_OUT_EN
    assign w_early = (bus.i_data2 == '0) || (w_mag2 > w_mag1);
`else
    assign w_early = 1'b0;
`endif

    // Multiply: operands sign- or zero-extended to XLEN+1 bits; the low
    // 2*XLEN bits of the product are exact in either case.
    logic                     w_sa, w_sb;
    logic signed [XLEN:0]     w_ma, w_mb;
    logic signed [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]          w_mul_res;

    assign w_sa      = (r_op[1:0] != 2'b11);
    assign w_sb      = (r_op[1:0] == 2'b01);
    assign w_ma      = {w_sa && r_a[XLEN-1], r_a};
    assign w_mb      = {w_sb && r_b[XLEN-1], r_b};
    assign w_prod    = w_ma * w_mb;
    assign w_mul_res = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    // One restoring-division step; the shifted partial remainder needs XLEN+1 bits
    logic [XLEN:0]   w_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_sub;

    assign w_sh  = {r_rem, r_a[XLEN-1]};
    assign w_ge  = (w_sh >= {1'b0, r_b});
    assign w_sub = w_sh[XLEN-1:0] - r_b;

    // Sign fix: a zero divisor never negates the quotient (neg_q cleared at entry)
    logic [XLEN-1:0] w_fix;
    assign w_fix = r_op[1] ? (r_neg_r ? -r_rem : r_rem)
                           : (r_neg_q ? -r_a   : r_a);

    // State register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next-state logic; KILL from any busy state wins over everything
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = bus.i_op[2] ? S_DIV : S_MUL;
            S_MUL:  w_next = S_DONE;
            S_DIV:  if (r_cnt == '0) w_next = S_FIX;
            S_FIX:  w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (bus.i_kill && r_state != S_IDLE) w_next = S_IDLE;
    end

    // Datapath: operand capture, divide iterations, result register
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_op     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_eo     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op <= bus.i_op;
                    if (bus.i_op[2]) begin
                        // Early-out preloads final quotient/remainder magnitudes
                        // and spends one idle DIV cycle before the sign fix.
                        r_a     <= w_early ? ((bus.i_data2 == '0) ? '1 : '0) : w_mag1;
                        r_rem   <= w_early ? w_mag1 : '0;
                        r_b     <= w_mag2;
                        r_cnt   <= w_early ? '0 : CNT_W'(XLEN-1);
                        r_eo    <= w_early;
                        r_neg_q <= (w_neg1 ^ w_neg2) && (bus.i_data2 != '0);
                        r_neg_r <= w_neg1;
                    end else begin
                        r_a <= bus.i_data1;
                        r_b <= bus.i_data2;
                    end
                end
                S_MUL: if (!bus.i_kill) r_result <= w_mul_res;
                S_DIV: if (!r_eo) begin
                    r_a   <= {r_a[XLEN-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_sh[XLEN-1:0];
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_FIX: if (!bus.i_kill) r_result <= w_fix;
                default: ;
            endcase
        end
    end

    assign bus.o_ready  = (r_state == S_IDLE);
    assign bus.o_busy   = (r_state != S_IDLE);
    assign bus.o_done   = (r_state == S_DONE);
    assign bus.o_result = r_result;

endmodule
